// File: rtl/pkg_input_queue_pkg.sv
// ---------------------------------------------------------------------------
// pkg_input_queue_pkg
//   Shared definitions for the per-requester packet input queue:
//   FSM state encodings and the flit sideband layout stored next to the
//   payload in the FIFO.
// ---------------------------------------------------------------------------
package pkg_input_queue_pkg;

  // Sideband bits stored with every flit: {sop, eop}.
  localparam int SB_W = 2;

  typedef enum logic [1:0] {
    PIQ_IDLE = 2'd0,
    PIQ_REQ  = 2'd1,
    PIQ_SEND = 2'd2
  } piq_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } flit_sb_t;

endpackage

// File: rtl/pkg_input_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// pkg_sync_fifo
//   Single-clock FIFO with combinational (first-word-fall-through) head read.
//   Pointers wrap modulo DEPTH; count runs 0..DEPTH.
// Ports
//   clk    in   clock, all state on posedge
//   rst    in   synchronous active-low reset (empties the FIFO)
//   flush  in   synchronous flush, same effect as reset on pointers/count
//   push   in   write din (ignored when full or flushing)
//   din    in   WIDTH-bit write data
//   pop    in   drop head entry (ignored when empty or flushing)
//   dout   out  WIDTH-bit head entry (valid while !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module pkg_sync_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from count, so
  // stale entries are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pkg_input_queue.sv
// ---------------------------------------------------------------------------
// pkg_input_queue
//   Per-requester packet input queue in front of pkg_arbiter5. Flits are
//   buffered; req is raised once a whole packet is stored; on grant that
//   packet is streamed out and pkt_done pulses one cycle after its eop flit
//   is accepted downstream.
//
//   Build option: PKG_CUT_THROUGH_EN
//     defined   - request as soon as a sop flit is at the head, an empty FIFO
//                 mid-packet is a bubble, ovf_err tied to 0.
//     undefined - store-and-forward; ovf_err flags a full FIFO holding no
//                 complete packet and flushes the queue while it is set.
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   in_valid/in_ready/in_data     upstream flit handshake and payload
//   in_sop/in_eop                 packet delimiters stored with the flit
//   req, gnt                      request to / grant from the arbiter
//   out_valid/out_ready/out_data  flit stream toward the output mux
//   out_sop/out_eop               delimiters of the FIFO head flit
//   pkt_done                      1-cycle pulse after the eop flit pops
//   ovf_err                       sticky deadlock flag, cleared by reset
// ---------------------------------------------------------------------------
module pkg_input_queue
  import pkg_input_queue_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              req,
  input  logic              gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              pkt_done,
  output logic              ovf_err
);

  localparam int FW = DATA_W + SB_W;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  piq_state_e    state;
  piq_state_e    state_nxt;
  logic          full;
  logic          empty;
  logic          flush;
  logic          push;
  logic          pop;
  logic          eop_push;
  logic          eop_pop;
  logic          start;
  logic [AW:0]   pkt_cnt;
  logic [AW:0]   pkt_cnt_nxt;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  flit_sb_t      head_sb;

  assign fifo_din = {in_sop, in_eop, in_data};
  assign head_sb  = flit_sb_t'(fifo_dout[FW-1 -: SB_W]);
  assign out_data = fifo_dout[DATA_W-1:0];
  assign out_sop  = head_sb.sop;
  assign out_eop  = head_sb.eop;

  assign in_ready = !full;
  // While flushing, accepted flits are thrown away rather than stored.
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;
  assign eop_push = push && in_eop;
  assign eop_pop  = pop && head_sb.eop;

  pkg_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // ---------------------------------------------------------------------
  // Stored complete-packet count (number of eop flits in the FIFO).
  // ---------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    unique case ({eop_push, eop_pop})
      2'b10:   pkt_cnt_nxt = pkt_cnt + CNT_ONE;
      2'b01:   pkt_cnt_nxt = pkt_cnt - CNT_ONE;
      default: pkt_cnt_nxt = pkt_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) pkt_cnt <= '0;
    else               pkt_cnt <= pkt_cnt_nxt;
  end

  // ---------------------------------------------------------------------
  // Request start condition and overflow handling (build dependent).
  // Start looks at the post-edge view so req rises the cycle right after
  // the qualifying flit is written.
  // ---------------------------------------------------------------------
`ifdef PKG_CUT_THROUGH_EN
  assign start   = (!empty && head_sb.sop) || (empty && push && in_sop);
  assign flush   = 1'b0;
  assign ovf_err = 1'b0;
`else
  assign start   = (pkt_cnt_nxt != '0);
  // A full FIFO with no eop inside can never drain: flag it and keep the
  // queue flushed from then on.
  assign flush   = ovf_err;

  always_ff @(posedge clk) begin
    if (!rst)                          ovf_err <= 1'b0;
    else if (full && pkt_cnt == '0)    ovf_err <= 1'b1;
  end
`endif

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) state <= PIQ_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      PIQ_IDLE: if (start)   state_nxt = PIQ_REQ;
      PIQ_REQ:  if (gnt)     state_nxt = PIQ_SEND;
      PIQ_SEND: if (eop_pop) state_nxt = PIQ_IDLE;
      default:               state_nxt = PIQ_IDLE;
    endcase
    if (flush) state_nxt = PIQ_IDLE;
  end

  always_comb begin
    req       = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      PIQ_REQ:  req       = 1'b1;
      PIQ_SEND: out_valid = !empty;
      default: ;
    endcase
  end

  // pkt_done is the registered image of the eop pop.
  always_ff @(posedge clk) begin
    if (!rst) pkt_done <= 1'b0;
    else      pkt_done <= eop_pop;
  end

endmodule

// File: tb/tb_pkg_input_queue.sv
// ---------------------------------------------------------------------------
// tb_pkg_input_queue
//   Self-checking bench for pkg_input_queue (store-and-forward build):
//   a cycle table for the basic packet, hand sequences for the multi-cycle
//   corners, then randomized traffic against a flit-queue reference model.
// ---------------------------------------------------------------------------
module tb_pkg_input_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              req;
  logic              gnt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              pkt_done;
  logic              ovf_err;

  always #5 clk = ~clk;

  pkg_input_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .pkt_done  (pkt_done),
    .ovf_err   (ovf_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic s, input logic e);
    in_valid = v;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Cycle table record: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              sop;
    logic              eop;
    logic              gnt;
    logic              out_ready;
    logic              e_req;
    logic              e_ov;
    logic [DATA_W-1:0] e_data;
    logic              e_pd;
    logic              e_in_ready;
  } vec_t;

  vec_t vt[8];

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              sop;
    logic              eop;
  } flit_t;

  flit_t mq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] pkt3 [3];
    logic [DATA_W-1:0] got [$];
    logic [DATA_W-1:0] exp5 [5];
    logic              rdy_pat [4];
    logic              prev_req;
    int                idx;
    int                pd_cnt;
    int                req_phases;

    drive(1'b0, '0, 1'b0, 1'b0);
    gnt       = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    tick();

    // ---------------- reset state ----------------
    check("rst_req",      req,       1'b0);
    check("rst_ov",       out_valid, 1'b0);
    check("rst_pd",       pkt_done,  1'b0);
    check("rst_ovf",      ovf_err,   1'b0);
    check("rst_in_ready", in_ready,  1'b1);
    rst = 1'b1;

    // ---------------- test 1: table-driven 3-flit packet ----------------
    //          v     data      sop   eop   gnt   ordy   req   ov    data      pd    irdy
    vt[0] = '{1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1};
    vt[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1};
    vt[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    vt[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b1};
    vt[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1};
    vt[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
    vt[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].in_valid, vt[i].in_data, vt[i].sop, vt[i].eop);
      gnt       = vt[i].gnt;
      out_ready = vt[i].out_ready;
      tick();
      check($sformatf("t1_req_%0d", i), req,       vt[i].e_req);
      check($sformatf("t1_ov_%0d", i),  out_valid, vt[i].e_ov);
      check($sformatf("t1_pd_%0d", i),  pkt_done,  vt[i].e_pd);
      check($sformatf("t1_ir_%0d", i),  in_ready,  vt[i].e_in_ready);
      if (vt[i].e_ov) check($sformatf("t1_data_%0d", i), out_data, vt[i].e_data);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    gnt = 1'b0;
    out_ready = 1'b0;

    // ---------------- test 2: request held without grant ----------------
    drive(1'b1, 32'hB0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hB1, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t2_req_up", req, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t2_req_hold_%0d", i), req,       1'b1);
      check($sformatf("t2_ov_hold_%0d", i),  out_valid, 1'b0);
    end
    gnt = 1'b1; tick(); gnt = 1'b0;
    check("t2_send_req", req,       1'b0);
    check("t2_send_ov",  out_valid, 1'b1);
    check("t2_send_d0",  out_data,  32'hB0);
    check("t2_send_sop", out_sop,   1'b1);
    out_ready = 1'b1; tick();
    check("t2_send_d1",  out_data,  32'hB1);
    check("t2_send_eop", out_eop,   1'b1);
    tick();
    check("t2_pd",       pkt_done,  1'b1);
    out_ready = 1'b0; tick();
    check("t2_pd_clr",   pkt_done,  1'b0);

    // ---------------- test 3: out_ready back-pressure ----------------
    pkt3[0] = 32'hC0; pkt3[1] = 32'hC1; pkt3[2] = 32'hC2;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pkt3[i], i == 0, i == 2);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    gnt = 1'b1; tick(); gnt = 1'b0;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b1; rdy_pat[3] = 1'b1;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      out_ready = rdy_pat[k];
      check($sformatf("t3_ov_%0d", k),   out_valid, 1'b1);
      check($sformatf("t3_data_%0d", k), out_data,  pkt3[idx]);
      tick();
      if (rdy_pat[k]) idx++;
      if (k < 3) check($sformatf("t3_pd_%0d", k), pkt_done, 1'b0);
    end
    check("t3_pd", pkt_done, 1'b1);
    out_ready = 1'b0;
    tick();

    // ---------------- test 4a: fill to full with eop on last flit ----------------
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t4_ir_%0d", i), in_ready, 1'b1);
      drive(1'b1, 32'h100 + i, i == 0, i == DEPTH - 1);
      tick();
    end
    check("t4_full_ir",  in_ready, 1'b0);
    check("t4_full_req", req,      1'b1);
    check("t4_full_ovf", ovf_err,  1'b0);
    drive(1'b1, 32'hEE, 1'b1, 1'b0);  // offered while full: must not be stored
    tick();
    check("t4_hold_ir",  in_ready, 1'b0);
    check("t4_hold_ovf", ovf_err,  1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    gnt = 1'b1; tick(); gnt = 1'b0;
    check("t4_send_ir", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t4_ov_%0d", i),   out_valid, 1'b1);
      check($sformatf("t4_data_%0d", i), out_data,  32'h100 + i);
      tick();
      if (i == 0) check("t4_ir_after_pop", in_ready, 1'b1);
    end
    check("t4_pd",       pkt_done,  1'b1);
    check("t4_drain_ov", out_valid, 1'b0);
    out_ready = 1'b0;
    tick();

    // ---------------- test 4b: full with no eop -> ovf_err ----------------
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h200 + i, i == 0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t4b_ir",       in_ready, 1'b0);
    check("t4b_ovf_pre",  ovf_err,  1'b0);
    tick();
    check("t4b_ovf_set",  ovf_err,  1'b1);
    tick();
    check("t4b_flush_ir", in_ready, 1'b1);
    drive(1'b1, 32'h300, 1'b1, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0);      tick();
    tick();
    check("t4b_drop_req", req,       1'b0);
    check("t4b_drop_ov",  out_valid, 1'b0);
    check("t4b_sticky",   ovf_err,   1'b1);
    do_reset();
    check("t4b_rst_ovf",  ovf_err,   1'b0);

    // ---------------- test 5: two queued packets ----------------
    exp5[0] = 32'hD0; exp5[1] = 32'hD1; exp5[2] = 32'hE0; exp5[3] = 32'hE1; exp5[4] = 32'hE2;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, exp5[i], (i == 0) || (i == 2), (i == 1) || (i == 4));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    gnt = 1'b1;
    out_ready = 1'b1;
    prev_req = 1'b0;
    pd_cnt = 0;
    req_phases = 0;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (req && !prev_req) req_phases++;
      prev_req = req;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      if (pkt_done) pd_cnt++;
    end
    gnt = 1'b0;
    out_ready = 1'b0;
    check("t5_req_phases", req_phases, 2);
    check("t5_pd_pulses",  pd_cnt,     2);
    check("t5_flit_cnt",   got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check($sformatf("t5_data_%0d", i), got[i], exp5[i]);

    // ---------------- test 6: reset in the middle of SEND ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF0 + i, i == 0, i == 2);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    gnt = 1'b1; tick(); gnt = 1'b0;
    out_ready = 1'b1; tick();
    check("t6_mid_ov", out_valid, 1'b1);
    rst = 1'b0; tick(); rst = 1'b1;
    check("t6_req", req,       1'b0);
    check("t6_ov",  out_valid, 1'b0);
    check("t6_ir",  in_ready,  1'b1);
    check("t6_pd",  pkt_done,  1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_idle_req_%0d", i), req,       1'b0);
      check($sformatf("t6_idle_ov_%0d", i),  out_valid, 1'b0);
    end

    // ---------------- random traffic vs flit-queue model ----------------
    do_reset();
    mq.delete();
    begin
      int   rem;
      logic first;
      logic did_push, did_pop, pop_eop;
      int   complete;
      flit_t f;
      rem = 0;
      first = 1'b0;
      for (int c = 0; c < 2400; c++) begin
        logic drain;
        drain = (c >= 2000);
        if (rem == 0) begin
          rem   = $urandom_range(1, 5);
          first = 1'b1;
        end
        drive(drain ? 1'b0 : ($urandom_range(0, 2) != 0), $urandom, first, rem == 1);
        gnt       = drain ? 1'b1 : $urandom_range(0, 1);
        out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);

        check("rnd_ov_nonempty", out_valid && (mq.size() == 0), 1'b0);
        if (out_valid && mq.size() > 0) begin
          check("rnd_data", out_data, mq[0].d);
          check("rnd_sop",  out_sop,  mq[0].sop);
          check("rnd_eop",  out_eop,  mq[0].eop);
        end
        did_push = in_valid && in_ready;
        did_pop  = out_valid && out_ready;
        pop_eop  = out_eop;
        f.d   = in_data;
        f.sop = in_sop;
        f.eop = in_eop;
        tick();

        if (did_pop && mq.size() > 0) void'(mq.pop_front());
        if (did_push) begin
          mq.push_back(f);
          first = 1'b0;
          rem--;
        end
        complete = 0;
        foreach (mq[j]) if (mq[j].eop) complete++;
        check("rnd_pd",       pkt_done, did_pop && pop_eop);
        check("rnd_in_ready", in_ready, mq.size() < DEPTH);
        check("rnd_req_pkt",  req && (complete == 0), 1'b0);
        check("rnd_ovf",      ovf_err, 1'b0);
      end
      complete = 0;
      foreach (mq[j]) if (mq[j].eop) complete++;
      check("rnd_drained", complete, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
